// File: rtl/axis_skid_buffer_pkg.sv
// Shared types and helpers for the AXI-Stream skid buffer.
package axis_skid_buffer_pkg;

   // Occupancy of the buffer: nothing, one word in main, or main plus skid.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

   // Data width in bits for a width given in bytes.
   function automatic int nb_of(input int n);
      return n * 8;
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice. Every output, including in_tready,
// comes straight from a flop, so neither the valid nor the ready path is
// combinational through this block. The skid register catches the one word
// that can arrive in the cycle after the downstream stalls.
module axis_skid_buffer
   import axis_skid_buffer_pkg::*;
#(
   parameter  int n  = 4,
   localparam int nb = nb_of(n)
) (
   input  logic          aclk,
   input  logic          aresetn,
   input  logic [nb-1:0] in_tdata,
   input  logic          in_tvalid,
   output logic          in_tready,
   output logic [nb-1:0] out_tdata,
   output logic          out_tvalid,
   input  logic          out_tready
);

   skid_state_t   state_reg, state_next;
   logic [nb-1:0] main_reg, main_next;
   logic [nb-1:0] skid_reg, skid_next;
   logic          in_tready_reg;
   logic          out_tvalid_reg;
   logic          in_xfer;
   logic          out_xfer;

   // Handshakes use the registered flags, so they only depend on flops and
   // the partner's signal.
   assign in_xfer  = in_tvalid & in_tready_reg;
   assign out_xfer = out_tvalid_reg & out_tready;

   assign in_tready  = in_tready_reg;
   assign out_tvalid = out_tvalid_reg;
   assign out_tdata  = main_reg;

   // Next-state and data steering for the main/skid pair.
   always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      skid_next  = skid_reg;
      case (state_reg)
         EMPTY: begin
            if (in_xfer) begin
               state_next = BUSY;
               main_next  = in_tdata;
            end
         end
         BUSY: begin
            if (in_xfer && out_xfer) begin
               main_next = in_tdata;
            end else if (in_xfer) begin
               state_next = FULL;
               skid_next  = in_tdata;
            end else if (out_xfer) begin
               state_next = EMPTY;
            end
         end
         FULL: begin
            // in_tready is low here, so only the output side can move.
            if (out_xfer) begin
               state_next = BUSY;
               main_next  = skid_reg;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
   end

   // State, data and the registered handshake flags. The flags are computed
   // from the next state so they are valid in the same cycle as the data.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg      <= EMPTY;
         main_reg       <= '0;
         skid_reg       <= '0;
         in_tready_reg  <= 1'b0;
         out_tvalid_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         main_reg       <= main_next;
         skid_reg       <= skid_next;
         in_tready_reg  <= (state_next != FULL);
         out_tvalid_reg <= (state_next != EMPTY);
      end
   end

`ifndef SYNTHESIS
   // A stalled output word must not change or disappear.
   a_stall_stable : assert property (@(posedge aclk) disable iff (!aresetn)
      (out_tvalid && !out_tready) |=> (out_tvalid && $stable(out_tdata)));

   // The block never advertises room while the skid register is occupied.
   a_full_not_ready : assert property (@(posedge aclk) disable iff (!aresetn)
      (state_reg == FULL) |-> !in_tready);
`endif

endmodule

// File: tb/tb_axis_skid_buffer.sv
// Self-checking bench for axis_skid_buffer. The reference model is a FIFO
// of accepted words: out_tvalid means "model non-empty", out_tdata is its
// head, and in_tready means "fewer than two words held".
module tb_axis_skid_buffer;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [31:0] in_tdata;
   logic        in_tvalid;
   logic        in_tready;
   logic [31:0] out_tdata;
   logic        out_tvalid;
   logic        out_tready;

   int          n_tests = 0;
   int          n_fail  = 0;

   logic [31:0] model_q[$];
   logic [31:0] src_q[$];
   bit          rdy_ok;
   int          gap_lo, gap_hi, gap_cnt;
   int          n_in, n_out;

   axis_skid_buffer #(.n(4)) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .in_tdata   (in_tdata),
      .in_tvalid  (in_tvalid),
      .in_tready  (in_tready),
      .out_tdata  (out_tdata),
      .out_tvalid (out_tvalid),
      .out_tready (out_tready)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Compare DUT outputs with what the FIFO model says they must be.
   task automatic check_state();
      check("out_tvalid", 64'(out_tvalid), 64'(model_q.size() > 0));
      check("in_tready", 64'(in_tready), 64'(rdy_ok && (model_q.size() < 2)));
      if (model_q.size() > 0)
         check("out_tdata", 64'(out_tdata), 64'(model_q[0]));
   endtask

   // Present the next source word once the previous one is gone and the
   // requested idle gap has elapsed. Idle cycles carry junk data.
   task automatic src_load();
      if (!in_tvalid && aresetn) begin
         if (gap_cnt > 0) begin
            gap_cnt--;
            in_tdata = $urandom;
         end else if (src_q.size() > 0) begin
            in_tdata  = src_q.pop_front();
            in_tvalid = 1'b1;
            gap_cnt   = $urandom_range(gap_hi, gap_lo);
         end else begin
            in_tdata = $urandom;
         end
      end
   endtask

   // One clock cycle: note the handshakes, clock, update model, check.
   task automatic tick(input bit ordy);
      bit          hs_in, hs_out, rst_at;
      logic [31:0] din;
      out_tready = ordy;
      hs_in  = in_tvalid && in_tready;
      hs_out = out_tvalid && out_tready;
      din    = in_tdata;
      rst_at = aresetn;
      @(posedge aclk);
      #1;
      if (!aresetn) begin
         model_q.delete();
         rdy_ok = 1'b0;
      end else begin
         if (hs_out && model_q.size() > 0) begin
            void'(model_q.pop_front());
            n_out++;
         end
         if (hs_in) begin
            model_q.push_back(din);
            n_in++;
         end
         if (rst_at) rdy_ok = 1'b1;
      end
      check_state();
      if (hs_in) in_tvalid = 1'b0;
      src_load();
   endtask

   // Run until every source word has passed through, with out_tready either
   // held high or toggled in random high (0..6) / low (1..6) runs.
   task automatic run_until_idle(input bit random_rdy, input int max_cycles);
      int cyc  = 0;
      bit r    = 1'b1;
      int left = 1000000;
      if (random_rdy) left = $urandom_range(6, 0);
      while (!(src_q.size() == 0 && !in_tvalid && model_q.size() == 0)) begin
         if (cyc >= max_cycles) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d cycles required < %0d", cyc, max_cycles);
            break;
         end
         if (random_rdy && left == 0) begin
            r    = !r;
            left = r ? $urandom_range(6, 0) : $urandom_range(6, 1);
            if (left == 0) begin
               r    = !r;
               left = $urandom_range(6, 1);
            end
         end
         tick(r);
         left--;
         cyc++;
      end
   endtask

   initial begin
      logic [31:0] w;
      int          k;
      aresetn    = 1'b0;
      in_tvalid  = 1'b0;
      in_tdata   = '0;
      out_tready = 1'b0;
      rdy_ok     = 1'b0;
      gap_lo     = 0;
      gap_hi     = 0;
      gap_cnt    = 0;
      n_in       = 0;
      n_out      = 0;

      // Reset state
      #2;
      check("rst_out_tvalid", 64'(out_tvalid), 64'(0));
      check("rst_in_tready", 64'(in_tready), 64'(0));
      check("rst_out_tdata", 64'(out_tdata), 64'(0));
      tick(1'b0);
      tick(1'b0);
      aresetn = 1'b1;
      tick(1'b0);
      check("rel_in_tready", 64'(in_tready), 64'(1));

      // Back-to-back flow
      src_q = '{32'h30313233, 32'h34353637, 32'h38396162};
      src_load();
      run_until_idle(1'b0, 20);
      check("b2b_count", 64'(n_out), 64'(3));

      // Stall fill: main holds 0123, skid takes 4567, 89ab waits
      src_q = '{32'h30313233, 32'h34353637, 32'h38396162};
      src_load();
      for (int i = 0; i < 4; i++) tick(1'b0);
      check("stall_hold", 64'(out_tdata), 64'(32'h30313233));
      check("stall_tready", 64'(in_tready), 64'(0));
      check("stall_waiting", 64'(in_tdata), 64'(32'h38396162));
      run_until_idle(1'b0, 20);

      // Gapped input
      gap_lo = 1;
      gap_hi = 1;
      src_q = '{32'hdeadbeef, 32'h01020304, 32'hffffffff, 32'h00000000};
      src_load();
      run_until_idle(1'b0, 30);

      // Random soak: 8 wrapping ASCII letters per word, low 4 bytes kept
      gap_lo = 0;
      gap_hi = 3;
      n_in   = 0;
      n_out  = 0;
      for (int i = 0; i < 500; i++) begin
         w = '0;
         for (int j = 4; j < 8; j++) begin
            k = 65 + ((8 * i + j) % 26);
            w = {w[23:0], k[7:0]};
         end
         src_q.push_back(w);
      end
      src_load();
      run_until_idle(1'b1, 20000);
      check("soak_in_eq_out", 64'(n_out), 64'(n_in));
      check("soak_count", 64'(n_in), 64'(500));

      // Reset mid-stream while FULL
      gap_lo = 0;
      gap_hi = 0;
      src_q = '{32'h11111111, 32'h22222222, 32'h33333333};
      src_load();
      for (int i = 0; i < 6 && model_q.size() < 2; i++) tick(1'b0);
      check("pre_rst_full", 64'(model_q.size()), 64'(2));
      aresetn = 1'b0;
      #1;
      check("mid_rst_out_tvalid", 64'(out_tvalid), 64'(0));
      check("mid_rst_in_tready", 64'(in_tready), 64'(0));
      check("mid_rst_out_tdata", 64'(out_tdata), 64'(0));
      src_q.delete();
      in_tvalid = 1'b0;
      gap_cnt   = 0;
      tick(1'b1);
      tick(1'b1);
      aresetn = 1'b1;
      tick(1'b1);
      check("post_rst_in_tready", 64'(in_tready), 64'(1));
      check("post_rst_no_stale", 64'(out_tvalid), 64'(0));
      tick(1'b1);
      src_q = '{32'hcafef00d};
      src_load();
      run_until_idle(1'b0, 20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
